// File: rtl/riscv_lsu.sv
// Load-store unit: turns decoder memory controls into a req/ack data-bus access,
// steering store lanes and extending load results, and stalls the core until done.
module riscv_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_stall_req_o,
  output logic [31:0] lsu_data_o,
  output logic        lsu_misalign_o,
  output logic        lsu_bus_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_ack_i,
  input  logic [31:0] data_rdata_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [2:0]       size_q, size_d;
  logic [1:0]       off_q, off_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             misaligned;
  logic             timeout_hit;
  logic [3:0]       be_new;
  logic [31:0]      wdata_new;
  logic [31:0]      load_ext;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;

  // size[1:0]: 0 = byte, 1 = half, 2/3 = word; size[2] selects zero extension.
  assign misaligned = ((lsu_size_i[1:0] == 2'b01) && lsu_addr_i[0]) ||
                      (lsu_size_i[1] && (lsu_addr_i[1:0] != 2'b00));

  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = lsu_data_i;
    if (lsu_we_i) begin
      unique case (lsu_size_i[1:0])
        2'b00: begin
          be_new    = 4'b0001 << lsu_addr_i[1:0];
          wdata_new = {4{lsu_data_i[7:0]}};
        end
        2'b01: begin
          be_new    = 4'b0011 << lsu_addr_i[1:0];
          wdata_new = {2{lsu_data_i[15:0]}};
        end
        default: begin
          be_new    = 4'b1111;
          wdata_new = lsu_data_i;
        end
      endcase
    end
  end

  always_comb begin
    ld_byte = data_rdata_i[8*off_q +: 8];
    ld_half = data_rdata_i[16*off_q[1] +: 16];
    unique case (size_q)
      3'd0:    load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    load_ext = {24'h0, ld_byte};
      3'd1:    load_ext = {{16{ld_half[15]}}, ld_half};
      3'd5:    load_ext = {16'h0, ld_half};
      default: load_ext = data_rdata_i;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d         = state_q;
    we_d            = we_q;
    size_d          = size_q;
    off_d           = off_q;
    addr_d          = addr_q;
    be_d            = be_q;
    wdata_d         = wdata_q;
    cnt_d           = cnt_q;
    rdata_d         = rdata_q;
    err_d           = err_q;
    lsu_stall_req_o = 1'b0;
    lsu_misalign_o  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (lsu_req_i) begin
          if (misaligned) begin
            lsu_misalign_o = 1'b1;
          end else begin
            lsu_stall_req_o = 1'b1;
            we_d            = lsu_we_i;
            size_d          = lsu_size_i;
            off_d           = lsu_addr_i[1:0];
            addr_d          = {lsu_addr_i[31:2], 2'b00};
            be_d            = be_new;
            wdata_d         = wdata_new;
            cnt_d           = '0;
            err_d           = 1'b0;
            state_d         = BUSY;
          end
        end
      end
      BUSY: begin
        lsu_stall_req_o = 1'b1;
        if (data_ack_i) begin
          rdata_d = we_q ? 32'h0 : load_ext;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (timeout_hit) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (cnt_q != CNT_LAST) begin
          // Saturating so a disabled timeout can never wrap the counter.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign data_req_o    = (state_q == BUSY);
  assign data_we_o     = we_q;
  assign data_be_o     = be_q;
  assign data_addr_o   = addr_q;
  assign data_wdata_o  = wdata_q;
  assign lsu_data_o    = rdata_q;
  assign lsu_bus_err_o = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: loads, stores, misalignment, timeout, reset and
// back-to-back accesses against hand-computed expectations.
module tb_riscv_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic        lsu_stall_req_o;
  logic [31:0] lsu_data_o;
  logic        lsu_misalign_o;
  logic        lsu_bus_err_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_ack_i;
  logic [31:0] data_rdata_i;

  int checks = 0;
  int errors = 0;

  riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .lsu_req_i       (lsu_req_i),
    .lsu_we_i        (lsu_we_i),
    .lsu_size_i      (lsu_size_i),
    .lsu_addr_i      (lsu_addr_i),
    .lsu_data_i      (lsu_data_i),
    .lsu_stall_req_o (lsu_stall_req_o),
    .lsu_data_o      (lsu_data_o),
    .lsu_misalign_o  (lsu_misalign_o),
    .lsu_bus_err_o   (lsu_bus_err_o),
    .data_req_o      (data_req_o),
    .data_we_o       (data_we_o),
    .data_be_o       (data_be_o),
    .data_addr_o     (data_addr_o),
    .data_wdata_o    (data_wdata_o),
    .data_ack_i      (data_ack_i),
    .data_rdata_i    (data_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Outcome of one access as seen on the pins.
  typedef struct {
    int          stall_n;
    int          busy_n;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        be_stable;
    logic [31:0] result;
    logic        err;
    logic        done_stall;
    bit          finished;
  } obs_t;

  // Drives one access; ack_at = BUSY cycle index that sees data_ack_i (0 = never).
  // Called and returns at 2 time units after a rising edge.
  task automatic run_access(input logic we, input logic [2:0] size,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int ack_at, input logic [31:0] rdata,
                            output obs_t o);
    o = '{0, 0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0};
    lsu_req_i  = 1'b1;
    lsu_we_i   = we;
    lsu_size_i = size;
    lsu_addr_i = addr;
    lsu_data_i = wd;
    #1;
    for (int c = 0; c < 40 && !o.finished; c++) begin
      if (lsu_stall_req_o) o.stall_n++;
      if (data_req_o) begin
        o.busy_n++;
        if (o.busy_n == 1) begin
          o.be = data_be_o; o.addr = data_addr_o; o.wdata = data_wdata_o; o.we = data_we_o;
        end else if (data_be_o !== o.be || data_addr_o !== o.addr || data_wdata_o !== o.wdata) begin
          o.be_stable = 1'b0;
        end
        if (o.busy_n == ack_at) begin
          data_ack_i   = 1'b1;
          data_rdata_i = rdata;
        end
      end else if (o.busy_n > 0) begin
        o.finished   = 1'b1;
        o.result     = lsu_data_o;
        o.err        = lsu_bus_err_o;
        o.done_stall = lsu_stall_req_o;
      end
      @(posedge clk_i); #1;
      data_ack_i   = 1'b0;
      data_rdata_i = 32'h0;
      if (o.finished) lsu_req_i = 1'b0;
      #1;
    end
  endtask

  task automatic expect_done(input string name, input obs_t o);
    checks++;
    if (!o.finished) begin
      errors++;
      $display("FAIL %s_done: access never completed within budget (busy=%0d)", name, o.busy_n);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 3'd0;
    lsu_addr_i = 32'h0; lsu_data_i = 32'h0; data_ack_i = 1'b0; data_rdata_i = 32'h0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    checks++;
    if ({lsu_stall_req_o, lsu_misalign_o, lsu_bus_err_o, data_req_o, data_we_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000",
               {lsu_stall_req_o, lsu_misalign_o, lsu_bus_err_o, data_req_o, data_we_o});
    end
    checks++;
    if ({data_be_o, data_addr_o, data_wdata_o, lsu_data_o} !== 100'h0) begin
      errors++;
      $display("FAIL reset_regs: be=%h addr=%h wdata=%h data=%h expected all 0",
               data_be_o, data_addr_o, data_wdata_o, lsu_data_o);
    end
  endtask

  task automatic test_load_byte();
    obs_t o;
    run_access(1'b0, 3'd0, 32'h0000_0103, 32'h0, 1, 32'h80AB_CDEF, o);
    expect_done("lb", o);
    checks++;
    if (o.stall_n != 2) begin errors++; $display("FAIL lb_stall: got %0d expected 2", o.stall_n); end
    checks++;
    if (o.be !== 4'b1111 || o.addr !== 32'h100 || o.we !== 1'b0) begin
      errors++; $display("FAIL lb_bus: be=%b addr=%h we=%b expected 1111 100 0", o.be, o.addr, o.we);
    end
    checks++;
    if (o.result !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL lb_data: got %h expected ffffff80", o.result);
    end
    checks++;
    if (o.done_stall !== 1'b0) begin errors++; $display("FAIL lb_done_stall: got %b expected 0", o.done_stall); end

    run_access(1'b0, 3'd4, 32'h0000_0103, 32'h0, 1, 32'h80AB_CDEF, o);
    expect_done("lbu", o);
    checks++;
    if (o.result !== 32'h0000_0080) begin
      errors++; $display("FAIL lbu_data: got %h expected 00000080", o.result);
    end

    run_access(1'b0, 3'd1, 32'h0000_0102, 32'h0, 2, 32'h80AB_CDEF, o);
    expect_done("lh", o);
    checks++;
    if (o.result !== 32'hFFFF_80AB) begin
      errors++; $display("FAIL lh_data: got %h expected ffff80ab", o.result);
    end
    run_access(1'b0, 3'd5, 32'h0000_0100, 32'h0, 1, 32'h80AB_CDEF, o);
    expect_done("lhu", o);
    checks++;
    if (o.result !== 32'h0000_CDEF) begin
      errors++; $display("FAIL lhu_data: got %h expected 0000cdef", o.result);
    end
  endtask

  task automatic test_store_half();
    obs_t o;
    run_access(1'b1, 3'd1, 32'h0000_0022, 32'h1234_5678, 3, 32'hDEAD_BEEF, o);
    expect_done("sh", o);
    checks++;
    if (o.addr !== 32'h20 || o.be !== 4'b1100 || o.wdata !== 32'h5678_5678 || o.we !== 1'b1) begin
      errors++;
      $display("FAIL sh_bus: addr=%h be=%b wdata=%h we=%b expected 20 1100 56785678 1",
               o.addr, o.be, o.wdata, o.we);
    end
    checks++;
    if (o.stall_n != 4 || o.busy_n != 3) begin
      errors++; $display("FAIL sh_stall: stall=%0d busy=%0d expected 4 3", o.stall_n, o.busy_n);
    end
    checks++;
    if (o.be_stable !== 1'b1) begin errors++; $display("FAIL sh_stable: bus outputs changed during BUSY"); end
    checks++;
    if (o.done_stall !== 1'b0 || o.result !== 32'h0) begin
      errors++; $display("FAIL sh_done: stall=%b data=%h expected 0 0", o.done_stall, o.result);
    end
  endtask

  task automatic test_misaligned();
    logic [2:0]  sizes [3] = '{3'd2, 3'd1, 3'd5};
    logic [31:0] addrs [3] = '{32'h42, 32'h41, 32'h43};
    for (int i = 0; i < 3; i++) begin
      int req_seen = 0;
      lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = sizes[i]; lsu_addr_i = addrs[i];
      #1;
      checks++;
      if (lsu_misalign_o !== 1'b1 || lsu_stall_req_o !== 1'b0 || data_req_o !== 1'b0) begin
        errors++;
        $display("FAIL misalign_%0d: mis=%b stall=%b req=%b expected 1 0 0",
                 i, lsu_misalign_o, lsu_stall_req_o, data_req_o);
      end
      @(posedge clk_i); #1 lsu_req_i = 1'b0; #1;
      for (int c = 0; c < 3; c++) begin
        if (data_req_o || lsu_misalign_o || lsu_stall_req_o) req_seen++;
        @(posedge clk_i); #2;
      end
      checks++;
      if (req_seen != 0) begin
        errors++; $display("FAIL misalign_quiet_%0d: %0d active cycles expected 0", i, req_seen);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_access(1'b0, 3'd2, 32'h0000_0040, 32'h0, 0, 32'h0, o);
    expect_done("timeout", o);
    checks++;
    if (o.busy_n != 4) begin errors++; $display("FAIL timeout_req_cycles: got %0d expected 4", o.busy_n); end
    checks++;
    if (o.err !== 1'b1 || o.result !== 32'h0 || o.done_stall !== 1'b0) begin
      errors++;
      $display("FAIL timeout_done: err=%b data=%h stall=%b expected 1 0 0", o.err, o.result, o.done_stall);
    end
    checks++;
    if (lsu_bus_err_o !== 1'b0 || data_req_o !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: err=%b req=%b expected 0 0", lsu_bus_err_o, data_req_o);
    end
  endtask

  task automatic test_reset_midop();
    obs_t o;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h80;
    @(posedge clk_i); #2;
    @(posedge clk_i); #2;
    checks++;
    if (data_req_o !== 1'b1) begin errors++; $display("FAIL midop_busy: req=%b expected 1", data_req_o); end
    rst_i = 1'b1; lsu_req_i = 1'b0;
    @(posedge clk_i); #1 rst_i = 1'b0; #1;
    checks++;
    if (data_req_o !== 1'b0 || lsu_stall_req_o !== 1'b0 || lsu_bus_err_o !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: req=%b stall=%b err=%b expected 0 0 0",
               data_req_o, lsu_stall_req_o, lsu_bus_err_o);
    end
    run_access(1'b1, 3'd2, 32'h0000_0010, 32'hCAFE_F00D, 1, 32'h0, o);
    expect_done("sw", o);
    checks++;
    if (o.be !== 4'b1111 || o.addr !== 32'h10 || o.wdata !== 32'hCAFE_F00D || o.we !== 1'b1) begin
      errors++;
      $display("FAIL sw_bus: be=%b addr=%h wdata=%h we=%b expected 1111 10 cafef00d 1",
               o.be, o.addr, o.wdata, o.we);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    run_access(1'b0, 3'd2, 32'h0000_0200, 32'h0, 1, 32'h1357_9BDF, o1);
    run_access(1'b1, 3'd0, 32'h0000_0001, 32'h1234_56A5, 1, 32'h0, o2);
    expect_done("b2b_lw", o1);
    expect_done("b2b_sb", o2);
    checks++;
    if (o1.result !== 32'h1357_9BDF || o1.done_stall !== 1'b0) begin
      errors++; $display("FAIL b2b_lw: data=%h stall=%b expected 13579bdf 0", o1.result, o1.done_stall);
    end
    checks++;
    if (o2.be !== 4'b0010 || o2.wdata !== 32'hA5A5_A5A5 || o2.addr !== 32'h0 || o2.stall_n != 2) begin
      errors++;
      $display("FAIL b2b_sb: be=%b wdata=%h addr=%h stall=%0d expected 0010 a5a5a5a5 0 2",
               o2.be, o2.wdata, o2.addr, o2.stall_n);
    end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_timeout();
    test_reset_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
